// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
// Serialises one frame per accepted start: HEADER bytes (MS first), the payload
// words (MS word first, each word MS byte first), then an optional checksum
// byte (sum of payload bytes mod 256). Every byte goes out as a start bit,
// 8 data bits LSB first, and STOP_BITS stop bits. Each bit lasts
// CLKS_PER_BIT clocks, and there is no idle gap between bytes of a frame.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high; aborts a frame in progress
//   payload_i    frame payload, copied to a shadow register on accepted start
//   start_i      frame request
//   ready_o      1 = idle, a start is accepted this cycle
//   busy_o       1 = frame in progress (inverse of ready_o)
//   done_o       one-cycle pulse in the first idle cycle after the last stop bit
//   txd_o        serial line, idle high, driven from a register
//   dbg_state_o  current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Handshake: start_i/ready_o behave as valid/ready. A transfer happens on a
// rising edge where both are 1. payload_i is sampled only at that edge.
// start_i while ready_o=0 is dropped, not queued.
// -----------------------------------------------------------------------------
module uart_frame_tx #(
   parameter int                  CLKS_PER_BIT = 434,
   parameter int                  HEADER_W     = 16,
   parameter logic [HEADER_W-1:0] HEADER       = 16'hAA55,
   parameter int                  WORD_W       = 16,
   parameter int                  N_WORDS      = 3,
   parameter int                  CHECKSUM_EN  = 1,
   parameter int                  STOP_BITS    = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_WORDS*WORD_W-1:0] payload_i,
   input  logic                      start_i,
   output logic                      ready_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      txd_o,
   output logic [1:0]                dbg_state_o
);

   localparam int PAY_W     = N_WORDS * WORD_W;
   localparam int FRAME_W   = HEADER_W + PAY_W;
   localparam int HDR_BYTES = HEADER_W / 8;
   localparam int NBYTES    = HDR_BYTES + PAY_W / 8 + CHECKSUM_EN;
   localparam int IDX_W     = $clog2(NBYTES + 1);
   localparam int BAUD_W    = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [BAUD_W-1:0]  r_baud, w_baud_nxt;
   logic [2:0]         r_bit, w_bit_nxt;      // data bit, or stop bit in STOP
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [FRAME_W-1:0] r_shift, w_shift_nxt;  // header+payload, current byte on top
   logic [7:0]         r_chk, w_chk_nxt;
   logic               r_txd, w_txd_nxt;
   logic               r_done, w_done_nxt;

   logic               w_bit_end;
   logic               w_last_byte;
   logic               w_is_chk;
   logic               w_is_pay;
   logic [7:0]         w_cur_byte;

   always_comb begin
      w_bit_end   = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
      w_last_byte = (r_idx == IDX_W'(NBYTES - 1));
      w_is_chk    = (CHECKSUM_EN != 0) && w_last_byte;
      w_is_pay    = !w_is_chk && (r_idx >= IDX_W'(HDR_BYTES));
      w_cur_byte  = w_is_chk ? r_chk : r_shift[FRAME_W-1 -: 8];

      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_chk_nxt   = r_chk;
      w_done_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt = S_START;
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
               w_idx_nxt   = '0;
               w_shift_nxt = {HEADER, payload_i};
               w_chk_nxt   = '0;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_nxt = S_DATA;
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
            end else begin
               w_baud_nxt = r_baud + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_baud_nxt = '0;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
                  w_bit_nxt   = '0;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end else begin
               w_baud_nxt = r_baud + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_baud_nxt = '0;
               if (r_bit == 3'(STOP_BITS - 1)) begin
                  w_bit_nxt = '0;
                  // Payload bytes join the checksum once fully sent, so the
                  // sum is complete before the checksum byte goes out.
                  if (w_is_pay) w_chk_nxt = r_chk + w_cur_byte;
                  if (w_last_byte) begin
                     w_state_nxt = S_IDLE;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = S_START;
                     w_idx_nxt   = r_idx + IDX_W'(1);
                     w_shift_nxt = {r_shift[FRAME_W-9:0], 8'h00};
                  end
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end else begin
               w_baud_nxt = r_baud + BAUD_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Line level is derived from the next state so the registered txd_o
      // changes on the same edge as the FSM.
      case (w_state_nxt)
         S_START: w_txd_nxt = 1'b0;
         S_DATA:  w_txd_nxt = w_cur_byte[w_bit_nxt];
         default: w_txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_chk   <= '0;
         r_txd   <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_chk   <= w_chk_nxt;
         r_txd   <= w_txd_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign ready_o     = (r_state == S_IDLE);
   assign busy_o      = ~ready_o;
   assign done_o      = r_done;
   assign txd_o       = r_txd;
   assign dbg_state_o = r_state;

endmodule
